// File: rtl/casu_ep_pkg.sv
// -----------------------------------------------------------------------------
// casu_ep_pkg
// Shared definitions for the CASU multi-region executable-pointer peripheral:
// FSM state encoding, CTRL/STATUS bit positions and register index helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package casu_ep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_APPLY = 2'd3
  } ep_state_t;

  // CTRL bit positions (MASK occupies [NUM_ER-1:0])
  localparam int CTRL_INVAL  = 13;
  localparam int CTRL_LOCK   = 14;
  localparam int CTRL_COMMIT = 15;

  // STATUS bit positions
  localparam int STAT_BUSY       = 0;
  localparam int STAT_DONE       = 1;
  localparam int STAT_ERR        = 2;
  localparam int STAT_OVR        = 3;
  localparam int STAT_LOCKED     = 4;
  localparam int STAT_ERRIDX_LSB = 8;

  // Largest supported region count; sizes the internal region arrays so that
  // a 3-bit index always addresses them exactly.
  localparam int MAX_ER = 8;

  function automatic int smin_idx(input int k);
    return 2 * k;
  endfunction

  function automatic int smax_idx(input int k);
    return 2 * k + 1;
  endfunction

  function automatic int ctrl_idx(input int num_er);
    return 2 * num_er;
  endfunction

  function automatic int stat_idx(input int num_er);
    return 2 * num_er + 1;
  endfunction

endpackage

// File: rtl/casu_ep_region.sv
// -----------------------------------------------------------------------------
// casu_ep_region
// One executable region: shadow ER_min/ER_max written from the bus with byte
// lanes, active copies loaded from the shadows on apply, and the valid bit.
// Ports:
//   mclk, puc_rst       clock, async active-high reset
//   i_din               bus write data
//   i_we_min/i_we_max   byte-lane enables for the shadow min/max registers
//   i_apply             copy shadow -> active and set valid
//   i_inval             clear valid (active values are kept)
//   o_smin/o_smax       shadow values (bus readback)
//   o_amin/o_amax       active values (to the monitor)
//   o_valid             region is enforced
// -----------------------------------------------------------------------------
module casu_ep_region #(
  parameter logic [15:0] MIN_RST   = 16'h0000,
  parameter logic [15:0] MAX_RST   = 16'h0000,
  parameter logic        VALID_RST = 1'b0
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [15:0] i_din,
  input  logic [1:0]  i_we_min,
  input  logic [1:0]  i_we_max,
  input  logic        i_apply,
  input  logic        i_inval,
  output logic [15:0] o_smin,
  output logic [15:0] o_smax,
  output logic [15:0] o_amin,
  output logic [15:0] o_amax,
  output logic        o_valid
);

  logic [15:0] r_smin;
  logic [15:0] r_smax;
  logic [15:0] r_amin;
  logic [15:0] r_amax;
  logic        r_valid;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_smin <= MIN_RST;
      r_smax <= MAX_RST;
    end else begin
      if (i_we_min[0]) r_smin[7:0]  <= i_din[7:0];
      if (i_we_min[1]) r_smin[15:8] <= i_din[15:8];
      if (i_we_max[0]) r_smax[7:0]  <= i_din[7:0];
      if (i_we_max[1]) r_smax[15:8] <= i_din[15:8];
    end
  end

  // Apply and invalidate never coincide in practice (bus writes are blocked
  // while the FSM is busy); apply wins if they ever do.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_amin  <= MIN_RST;
      r_amax  <= MAX_RST;
      r_valid <= VALID_RST;
    end else if (i_apply) begin
      r_amin  <= r_smin;
      r_amax  <= r_smax;
      r_valid <= 1'b1;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end
  end

  assign o_smin  = r_smin;
  assign o_smax  = r_smax;
  assign o_amin  = r_amin;
  assign o_amax  = r_amax;
  assign o_valid = r_valid;

endmodule

// File: rtl/casu_ep_multi_per.sv
// -----------------------------------------------------------------------------
// casu_ep_multi_per
// Multi-region executable-pointer peripheral on the openMSP430 peripheral bus.
// Software stages bounds in shadow registers and commits them atomically via
// a validate / request / apply sequence; the CASU monitor acknowledges each
// update before the active bounds change.
// Ports:
//   mclk, puc_rst           clock, async active-high reset
//   per_addr/per_din        bus word address / write data
//   per_en/per_we           bus enable / byte write enables (00 = read)
//   per_dout                combinational read data, 0 when not selected
//   er_min/er_max           active bounds, region k at [16k+15:16k]
//   er_valid                per-region enforce flags
//   upd_req/upd_ack         update handshake with the monitor
// Build option: define CASU_EP_LOCK_EN to enable the sticky CTRL.LOCK bit.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting; a pending commit (r_go) moves to CHECK
// ST_CHECK | one region per cycle, SMIN<=SMAX for masked regions
// ST_REQ   | upd_req high, waiting for upd_ack
// ST_APPLY | masked regions copy shadow -> active, DONE set
// -----------------------------------------------------------------------------
module casu_ep_multi_per
  import casu_ep_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR   = 15'h0140,
  parameter int          NUM_ER      = 4,
  parameter int          DEC_WD      = 4,
  parameter logic [15:0] ER0_MIN_RST = 16'hE000,
  parameter logic [15:0] ER0_MAX_RST = 16'hEFFF
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic [13:0]         per_addr,
  input  logic [15:0]         per_din,
  input  logic                per_en,
  input  logic [1:0]          per_we,
  output logic [15:0]         per_dout,
  output logic [16*NUM_ER-1:0] er_min,
  output logic [16*NUM_ER-1:0] er_max,
  output logic [NUM_ER-1:0]   er_valid,
  output logic                upd_req,
  input  logic                upd_ack
);

  localparam logic [DEC_WD-1:0] CTRL_IDX = DEC_WD'(ctrl_idx(NUM_ER));
  localparam logic [DEC_WD-1:0] STAT_IDX = DEC_WD'(stat_idx(NUM_ER));
  localparam logic [2:0]        LAST_IDX = 3'(NUM_ER - 1);

  ep_state_t   r_state;
  ep_state_t   w_state_nxt;
  logic        r_go;
  logic [7:0]  r_mask;
  logic [2:0]  r_cnt;
  logic        r_upd_req;
  logic        r_done;
  logic        r_err;
  logic        r_ovr;
  logic [2:0]  r_err_idx;

  logic                w_sel;
  logic [DEC_WD-1:0]   w_idx;
  logic                w_wr;
  logic                w_rd;
  logic                w_busy;
  logic                w_locked;
  logic                w_wr_ok;
  logic                w_ovr_set;
  logic                w_ctrl_wr;
  logic                w_commit;
  logic                w_inval;
  logic [NUM_ER-1:0]   w_mask_in;
  logic                w_mask_nz;
  logic                w_chk_fail;
  logic [15:0]         w_status;
  logic [15:0]         w_dout;
  logic [15:0]         w_smin [MAX_ER];
  logic [15:0]         w_smax [MAX_ER];

  // ---------------------------------------------------------------- decode
  assign w_sel = per_en && (per_addr[13:DEC_WD] == BASE_ADDR[14:DEC_WD+1]);
  assign w_idx = per_addr[DEC_WD-1:0];
  assign w_wr  = w_sel && (per_we != 2'b00);
  assign w_rd  = w_sel && (per_we == 2'b00);

  // r_go covers the cycle between the CTRL write and CHECK entry, so the
  // block already counts as busy there.
  assign w_busy = (r_state != ST_IDLE) || r_go;

  assign w_wr_ok   = w_wr && !w_busy && !w_locked;
  assign w_ovr_set = w_wr && w_busy && !w_locked;
  assign w_ctrl_wr = w_wr_ok && (w_idx == CTRL_IDX);
  assign w_mask_in = per_din[NUM_ER-1:0];
  assign w_mask_nz = |w_mask_in;
  assign w_commit  = w_ctrl_wr && per_din[CTRL_COMMIT];
  assign w_inval   = w_ctrl_wr && per_din[CTRL_INVAL];

`ifdef CASU_EP_LOCK_EN
  logic r_locked;

  // Evaluated against the pre-write lock state, so LOCK+COMMIT still starts
  // the commit in the same write.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) r_locked <= 1'b0;
    else if (w_ctrl_wr && per_din[CTRL_LOCK]) r_locked <= 1'b1;
  end

  assign w_locked = r_locked;
`else
  assign w_locked = 1'b0;
`endif

  // --------------------------------------------------------------- regions
  for (genvar k = 0; k < NUM_ER; k++) begin : g_reg
    logic [1:0] w_we_min;
    logic [1:0] w_we_max;
    logic       w_apply;

    assign w_we_min = (w_wr_ok && (w_idx == DEC_WD'(smin_idx(k)))) ? per_we : 2'b00;
    assign w_we_max = (w_wr_ok && (w_idx == DEC_WD'(smax_idx(k)))) ? per_we : 2'b00;
    assign w_apply  = (r_state == ST_APPLY) && r_mask[k];

    casu_ep_region #(
      .MIN_RST   ((k == 0) ? ER0_MIN_RST : 16'h0000),
      .MAX_RST   ((k == 0) ? ER0_MAX_RST : 16'h0000),
      .VALID_RST (k == 0)
    ) u_region (
      .mclk     (mclk),
      .puc_rst  (puc_rst),
      .i_din    (per_din),
      .i_we_min (w_we_min),
      .i_we_max (w_we_max),
      .i_apply  (w_apply),
      .i_inval  (w_inval && w_mask_in[k]),
      .o_smin   (w_smin[k]),
      .o_smax   (w_smax[k]),
      .o_amin   (er_min[16*k +: 16]),
      .o_amax   (er_max[16*k +: 16]),
      .o_valid  (er_valid[k])
    );
  end

  for (genvar k = NUM_ER; k < MAX_ER; k++) begin : g_pad
    assign w_smin[k] = 16'h0000;
    assign w_smax[k] = 16'h0000;
  end

  // -------------------------------------------------------------------- FSM
  assign w_chk_fail = (r_state == ST_CHECK) && r_mask[r_cnt] &&
                      (w_smin[r_cnt] > w_smax[r_cnt]);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (r_go) w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (w_chk_fail)              w_state_nxt = ST_IDLE;
        else if (r_cnt == LAST_IDX)  w_state_nxt = ST_REQ;
      end
      ST_REQ:   if (upd_ack) w_state_nxt = ST_APPLY;
      ST_APPLY: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state   <= ST_IDLE;
      r_go      <= 1'b0;
      r_mask    <= 8'h00;
      r_cnt     <= 3'd0;
      r_upd_req <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      r_err_idx <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_upd_req <= (w_state_nxt == ST_REQ);
      r_go      <= w_commit && w_mask_nz;

      if (w_commit && w_mask_nz) r_mask <= 8'(w_mask_in);

      if (r_state == ST_CHECK) r_cnt <= r_cnt + 3'd1;
      else                     r_cnt <= 3'd0;

      if (w_ovr_set) r_ovr <= 1'b1;

      // Later assignments override the CTRL-write clear.
      if (w_ctrl_wr) begin
        r_done    <= 1'b0;
        r_err     <= 1'b0;
        r_err_idx <= 3'd0;
      end
      if (w_commit && !w_mask_nz) r_done <= 1'b1;
      if (w_chk_fail) begin
        r_err     <= 1'b1;
        r_err_idx <= r_cnt;
      end
      if (r_state == ST_APPLY) r_done <= 1'b1;
    end
  end

  assign upd_req = r_upd_req;

  // --------------------------------------------------------------- readback
  assign w_status = {5'b0, r_err_idx, 3'b0, w_locked, r_ovr, r_err, r_done, w_busy};

  always_comb begin
    w_dout = 16'h0000;
    if (w_rd) begin
      for (int k = 0; k < NUM_ER; k++) begin
        if (w_idx == DEC_WD'(smin_idx(k))) w_dout = w_smin[k];
        if (w_idx == DEC_WD'(smax_idx(k))) w_dout = w_smax[k];
      end
      if (w_idx == STAT_IDX) w_dout = w_status;
    end
  end

  assign per_dout = w_dout;

endmodule
